// File: rtl/uart_bus_arbiter_if.sv
// Native valid/ready register bus used on both sides of the UART arbiter.
//   valid/wstrb/addr/wdata : request, driven by the bus master
//   ready/rdata            : completion pulse and read data, driven by the slave
// wstrb == 0 marks a read.
interface uart_bus_arbiter_if;
  logic        valid;
  logic        ready;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output valid, wstrb, addr, wdata, input  ready, rdata);
  modport slave  (input  valid, wstrb, addr, wdata, output ready, rdata);
endinterface

// File: rtl/uart_bus_arbiter.sv
// Two-master arbiter in front of the UART register slave.
// m0 = CPU, m1 = debug/boot-loader engine. Round-robin, one transaction per
// grant, with a mandatory idle cycle after each release so a data-register
// read can never be issued twice back to back. m1 may hold the slave across
// transactions with m1_lock, bounded by LOCK_MAX cycles.
// Ports:
//   clk, resetn  : clock, synchronous active-low reset
//   m0_bus       : CPU request bus (slave side of the arbiter)
//   m1_bus       : debug engine request bus
//   s_bus        : bus to the UART registers (master side of the arbiter)
//   m1_lock      : m1 asks to keep the grant across transactions
//   grant        : one-hot owner, 00 idle / 01 m0 / 10 m1
//   lock_expired : one-cycle pulse when a lock is force-released
module uart_bus_arbiter #(
  parameter int LOCK_MAX = 4096,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  uart_bus_arbiter_if.slave    m0_bus,
  uart_bus_arbiter_if.slave    m1_bus,
  uart_bus_arbiter_if.master   s_bus,
  input  logic                 m1_lock,
  output logic [1:0]           grant,
  output logic                 lock_expired
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_e;

  localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);

  state_e           state_q, state_d;
  logic             last_q,  last_d;   // owner of the last completed handshake
  logic [CNT_W-1:0] cnt_q,   cnt_d;    // cycles spent locked in OWN1

  logic expired;
  assign expired = (cnt_q >= LOCK_MAX_C);

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      last_q  <= 1'b1;   // m0 wins the first tie
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. cnt_d defaults to 0, which clears the counter both on
  // entry to OWN1 and whenever OWN1 is left.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (m0_bus.valid && (!m1_bus.valid || last_q)) state_d = OWN0;
        else if (m1_bus.valid)                         state_d = OWN1;
      end
      OWN0: begin
        if (!m0_bus.valid) begin
          state_d = IDLE;                 // abandoned request
        end else if (s_bus.ready) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end
      end
      OWN1: begin
        if (m1_bus.valid && s_bus.ready) last_d = 1'b1;
        // Stay while a transfer is still in flight (expiry never aborts it),
        // or while the lock is held and the window has not run out.
        if ((m1_bus.valid && !s_bus.ready) || (m1_lock && !expired)) begin
          // Saturate so a very long stalled transfer cannot wrap the count.
          cnt_d = (m1_lock && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: owner's request forwarded, completion steered back to it.
  always_comb begin
    grant         = 2'b00;
    lock_expired  = 1'b0;
    s_bus.valid   = 1'b0;
    s_bus.wstrb   = '0;
    s_bus.addr    = '0;
    s_bus.wdata   = '0;
    m0_bus.ready  = 1'b0;
    m0_bus.rdata  = '0;
    m1_bus.ready  = 1'b0;
    m1_bus.rdata  = '0;
    case (state_q)
      OWN0: begin
        grant = 2'b01;
        if (m0_bus.valid) begin
          s_bus.valid  = 1'b1;
          s_bus.wstrb  = m0_bus.wstrb;
          s_bus.addr   = m0_bus.addr;
          s_bus.wdata  = m0_bus.wdata;
          m0_bus.ready = s_bus.ready;
          if (s_bus.ready) m0_bus.rdata = s_bus.rdata;
        end
      end
      OWN1: begin
        grant = 2'b10;
        if (m1_bus.valid) begin
          s_bus.valid  = 1'b1;
          s_bus.wstrb  = m1_bus.wstrb;
          s_bus.addr   = m1_bus.addr;
          s_bus.wdata  = m1_bus.wdata;
          m1_bus.ready = s_bus.ready;
          if (s_bus.ready) m1_bus.rdata = s_bus.rdata;
        end
        // Forced release happens at a handshake, or at once if m1 is idle.
        lock_expired = m1_lock && expired && (s_bus.ready || !m1_bus.valid);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Directed bench for uart_bus_arbiter: arbitration latency, round-robin order,
// long slave stall, lock window expiry (LOCK_MAX=8), abandoned request,
// locked idle, and synchronous reset in the middle of a stalled transfer.
module tb_uart_bus_arbiter;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       m1_lock = 1'b0;
  logic [1:0] grant;
  logic       lock_expired;
  int         n_chk = 0;
  int         n_err = 0;
  int         ord[$];
  int         rem0, rem1;
  logic       prev_hs;

  uart_bus_arbiter_if m0_bus();
  uart_bus_arbiter_if m1_bus();
  uart_bus_arbiter_if s_bus();

  uart_bus_arbiter #(.LOCK_MAX(8), .CNT_W(16)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .m0_bus       (m0_bus),
    .m1_bus       (m1_bus),
    .s_bus        (s_bus),
    .m1_lock      (m1_lock),
    .grant        (grant),
    .lock_expired (lock_expired)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int m, input logic v, input logic [3:0] ws,
                     input logic [31:0] a, input logic [31:0] wd);
    if (m == 0) begin
      m0_bus.valid = v; m0_bus.wstrb = ws; m0_bus.addr = a; m0_bus.wdata = wd;
    end else begin
      m1_bus.valid = v; m1_bus.wstrb = ws; m1_bus.addr = a; m1_bus.wdata = wd;
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    m1_lock = 1'b0;
    req(0, 1'b0, 4'h0, 0, 0);
    req(1, 1'b0, 4'h0, 0, 0);
    s_bus.ready = 1'b0;
    s_bus.rdata = '0;
    step();
    step();
    resetn = 1'b1;
  endtask

  initial begin
    // ---- reset state and single m0 read -------------------------------
    do_reset();
    #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_svalid", 32'(s_bus.valid), 0);
    chk("rst_m0rdy", 32'(m0_bus.ready), 0);
    chk("rst_m1rdy", 32'(m1_bus.ready), 0);
    chk("rst_lockexp", 32'(lock_expired), 0);
    chk("rst_saddr", s_bus.addr, 0);
    chk("rst_m0rdata", m0_bus.rdata, 0);
    req(0, 1'b1, 4'h0, 32'h4, 0);
    #1 chk("t1_c0_svalid", 32'(s_bus.valid), 0);
    step(); #1;
    chk("t1_c1_svalid", 32'(s_bus.valid), 1);
    chk("t1_c1_grant", 32'(grant), 1);
    chk("t1_c1_saddr", s_bus.addr, 32'h4);
    chk("t1_c1_m0rdy", 32'(m0_bus.ready), 0);
    step();
    s_bus.ready = 1'b1; s_bus.rdata = 32'h41;
    #1;
    chk("t1_c2_m0rdy", 32'(m0_bus.ready), 1);
    chk("t1_c2_m0rdata", m0_bus.rdata, 32'h41);
    chk("t1_c2_m1rdata", m1_bus.rdata, 0);
    chk("t1_c2_m1rdy", 32'(m1_bus.ready), 0);
    step();
    req(0, 1'b0, 4'h0, 0, 0);
    s_bus.ready = 1'b0; s_bus.rdata = '0;
    #1;
    chk("t1_c3_grant", 32'(grant), 0);
    chk("t1_c3_svalid", 32'(s_bus.valid), 0);

    // ---- simultaneous requests, two rounds: m0,m1,m0,m1 ----------------
    do_reset();
    s_bus.ready = 1'b1; s_bus.rdata = 32'h77;
    req(0, 1'b1, 4'h0, 32'h4, 0);
    req(1, 1'b1, 4'h0, 32'h0, 0);
    rem0 = 2; rem1 = 2; prev_hs = 1'b0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (m0_bus.ready) begin ord.push_back(0); rem0--; end
      if (m1_bus.ready) begin ord.push_back(1); rem1--; end
      if (prev_hs) chk("t2_gap", 32'(s_bus.valid), 0);
      prev_hs = s_bus.valid && s_bus.ready;
      step();
      m0_bus.valid = (rem0 > 0);
      m1_bus.valid = (rem1 > 0);
    end
    chk("t2_count", 32'(ord.size()), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t2_order%0d", i), (i < ord.size()) ? 32'(ord[i]) : 32'hFF, 32'(i % 2));
    s_bus.ready = 1'b0; s_bus.rdata = '0;

    // ---- m0 write stalled 40 cycles, m1 waiting -----------------------
    step();
    req(0, 1'b1, 4'h1, 32'h4, 32'h55);
    #1;
    step();
    req(1, 1'b1, 4'h0, 32'h0, 0);
    #1;
    chk("t3_grant", 32'(grant), 1);
    chk("t3_wdata", s_bus.wdata, 32'h55);
    chk("t3_wstrb", 32'(s_bus.wstrb), 1);
    for (int k = 0; k < 40; k++) begin
      chk("t3_m1rdy_stall", 32'(m1_bus.ready), 0);
      chk("t3_grant_stall", 32'(grant), 1);
      step(); #1;
    end
    s_bus.ready = 1'b1;
    #1;
    chk("t3_m0rdy", 32'(m0_bus.ready), 1);
    chk("t3_m1rdy", 32'(m1_bus.ready), 0);
    step();
    req(0, 1'b0, 4'h0, 0, 0);
    s_bus.ready = 1'b0;
    #1;
    chk("t3_gap_grant", 32'(grant), 0);
    chk("t3_gap_m1rdy", 32'(m1_bus.ready), 0);
    step(); #1;
    chk("t3_m1_grant", 32'(grant), 2);
    s_bus.ready = 1'b1;
    #1 chk("t3_m1rdy_done", 32'(m1_bus.ready), 1);
    step();
    req(1, 1'b0, 4'h0, 0, 0);
    s_bus.ready = 1'b0;

    // ---- m1 locked burst, LOCK_MAX=8, m0 waiting -----------------------
    req(1, 1'b1, 4'hF, 32'h0, 32'h100);
    m1_lock = 1'b1;
    s_bus.ready = 1'b1;
    #1 chk("t4_c0_grant", 32'(grant), 0);
    for (int k = 0; k < 9; k++) begin
      step();
      req(0, 1'b1, 4'h0, 32'h4, 0);
      req(1, 1'b1, 4'hF, 32'h0, 32'(k + 1));
      #1;
      chk($sformatf("t4_grant%0d", k), 32'(grant), 2);
      chk($sformatf("t4_m1rdy%0d", k), 32'(m1_bus.ready), 1);
      chk($sformatf("t4_lockexp%0d", k), 32'(lock_expired), (k == 8) ? 1 : 0);
    end
    step(); #1;
    chk("t4_gap_grant", 32'(grant), 0);
    chk("t4_gap_svalid", 32'(s_bus.valid), 0);
    chk("t4_gap_lockexp", 32'(lock_expired), 0);
    step(); #1;
    chk("t4_m0_grant", 32'(grant), 1);
    chk("t4_m0rdy", 32'(m0_bus.ready), 1);
    step();
    req(0, 1'b0, 4'h0, 0, 0);
    req(1, 1'b0, 4'h0, 0, 0);
    m1_lock = 1'b0;
    s_bus.ready = 1'b0;

    // ---- m1 abandons request, no lock ----------------------------------
    req(1, 1'b1, 4'h0, 32'h4, 0);
    #1;
    step(); #1;
    chk("t5_grant", 32'(grant), 2);
    chk("t5_svalid", 32'(s_bus.valid), 1);
    step();
    req(1, 1'b0, 4'h0, 0, 0);
    #1;
    chk("t5_drop_svalid", 32'(s_bus.valid), 0);
    chk("t5_drop_m1rdy", 32'(m1_bus.ready), 0);
    step(); #1;
    chk("t5_idle_grant", 32'(grant), 0);

    // ---- locked m1 going idle keeps the grant until lock drops --------
    req(1, 1'b1, 4'h0, 32'h4, 0);
    m1_lock = 1'b1;
    #1;
    step();
    s_bus.ready = 1'b1;
    #1 chk("t5l_m1rdy", 32'(m1_bus.ready), 1);
    step();
    req(1, 1'b0, 4'h0, 0, 0);
    s_bus.ready = 1'b0;
    #1;
    chk("t5l_hold_grant", 32'(grant), 2);
    chk("t5l_hold_svalid", 32'(s_bus.valid), 0);
    step(); #1;
    chk("t5l_hold2_grant", 32'(grant), 2);
    m1_lock = 1'b0;
    #1 chk("t5l_unlock_grant", 32'(grant), 2);
    step(); #1;
    chk("t5l_rel_grant", 32'(grant), 0);

    // ---- reset during a stalled m0 transfer ----------------------------
    req(0, 1'b1, 4'h0, 32'h4, 0);
    #1;
    step();
    s_bus.ready = 1'b1;
    #1 chk("t6_m0rdy", 32'(m0_bus.ready), 1);
    step();
    s_bus.ready = 1'b0;
    #1 chk("t6_gap_grant", 32'(grant), 0);
    step(); #1;
    chk("t6_stall_grant", 32'(grant), 1);
    step();
    resetn = 1'b0;
    #1 chk("t6_rstlow_grant", 32'(grant), 1);
    step();
    resetn = 1'b1;
    req(1, 1'b1, 4'h0, 32'h0, 0);
    #1;
    chk("t6_rst_grant", 32'(grant), 0);
    chk("t6_rst_svalid", 32'(s_bus.valid), 0);
    chk("t6_rst_m0rdy", 32'(m0_bus.ready), 0);
    chk("t6_rst_m1rdy", 32'(m1_bus.ready), 0);
    step(); #1;
    chk("t6_tie_grant", 32'(grant), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/uart_bus_arbiter.md
Name: uart_bus_arbiter

Overview:
- Two-master arbiter sharing one UART register slave (divider register at addr[2]=0, data register at addr[2]=1) on the native valid/ready bus.
- Master 0 is the CPU; master 1 is the debug/boot-loader engine.
- Round-robin grant, one transaction per grant; master 1 may lock the slave for back-to-back transfers, up to a bounded lock window.
- Sits between the interconnect and the UART; the UART needs no changes.

Parameters:
LOCK_MAX, 4096, max cycles master 1 keeps a locked grant before forced release at the next handshake boundary (1..2^16-1)
CNT_W, 16, width of the lock-window counter

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
m0_valid  in  1  master 0 request; held until m0_ready
m0_ready  out  1  master 0 completion pulse
m0_wstrb  in  4  master 0 byte enables; 0 = read
m0_addr  in  32  master 0 address
m0_wdata  in  32  master 0 write data
m0_rdata  out  32  master 0 read data, valid with m0_ready
m1_valid  in  1  master 1 request
m1_ready  out  1  master 1 completion pulse
m1_wstrb  in  4  master 1 byte enables
m1_addr  in  32  master 1 address
m1_wdata  in  32  master 1 write data
m1_rdata  out  32  master 1 read data
m1_lock  in  1  master 1 requests grant retention across transactions
s_valid  out  1  slave request
s_ready  in  1  slave completion (combinational in slave; may stall many cycles on TX busy)
s_wstrb  out  4  slave byte enables
s_addr  out  32  slave address
s_wdata  out  32  slave write data
s_rdata  in  32  slave read data
grant  out  2  one-hot current owner: 00 idle, 01 m0, 10 m1
lock_expired  out  1  one-cycle pulse when a lock is force-released

Behaviour:
- Reset values: state IDLE; grant=00; last_owner=1, so m0 wins the first tie; lock counter=0; m*_ready=0; m*_rdata=0; s_valid=0; s_wstrb/s_addr/s_wdata=0; lock_expired=0.
- States: IDLE, OWN0, OWN1.
- IDLE: s_valid=0.
  - Only one master valid -> that master's OWN state next cycle.
  - Both valid -> the master not equal to last_owner.
  - Arbitration latency: exactly 1 cycle from valid to s_valid.
- OWNx, forwarding: s_valid=mx_valid; s_wstrb/s_addr/s_wdata=mx fields (0 when mx_valid=0).
- OWNx, handshake: on s_valid && s_ready, assert mx_ready=1 combinationally, mx_rdata=s_rdata that cycle, and set last_owner=x.
  - Next state: IDLE, except the OWN1 lock case below.
  - The non-owner's ready=0 and rdata=0 at all times.
- Mandatory idle gap: after every non-locked handshake, s_valid is 0 for at least one cycle. This prevents a second data-register read clearing the RX buffer twice.
- Abandoned request: in OWNx with mx_valid=0 and no lock -> IDLE next cycle; no ready issued.
- Lock (OWN1 only):
  - Lock counter increments every cycle in OWN1 while m1_lock=1; it clears on entry to OWN1 and on leaving OWN1.
  - At a handshake with m1_lock=1 and counter < LOCK_MAX -> stay OWN1, with no idle gap. m1 must drop valid or present a new request the cycle after m1_ready.
  - With m1_lock=1 and m1_valid=0 -> stay OWN1, s_valid=0.
  - m1_lock=0 while idle in OWN1 -> IDLE next cycle.
  - Counter >= LOCK_MAX: release at the next handshake (or immediately if m1_valid=0), go to IDLE, pulse lock_expired.
  - After a forced release, m1 cannot re-enter OWN1 while m0_valid is high: m0 wins by last_owner=1.
  - A transaction in flight is never aborted by lock expiry.
- m0_lock does not exist; OWN0 always releases after one transaction.
- Reset mid-transaction: everything returns to reset values next edge; the in-flight request is dropped with no ready.

Test Plan:
- m0 reads addr 0x4 alone, slave ready 1 cycle after s_valid with rdata 0x41 -> s_valid at cycle 1, m0_ready and m0_rdata=0x41 at cycle 2, grant 01 then 00.
- m0 and m1 valid in the same cycle after reset, both reads -> m0 served first, one idle cycle, then m1. Repeated twice -> order m0,m1,m0,m1.
- m0 writes 0x55 to addr 0x4 with s_ready held low 40 cycles (TX busy), m1 valid meanwhile -> m1 untouched and m1_ready=0 throughout. m0_ready exactly on the cycle s_ready rises; m1 granted 2 cycles later.
- LOCK_MAX=8, m1_lock=1, m1 issues back-to-back 1-cycle writes, m0 valid throughout -> no idle gap between m1 transfers. lock_expired pulses at the first handshake with counter >= 8; m0 is granted next.
- m1 granted, then drops m1_valid with m1_lock=0 before s_ready -> IDLE next cycle, m1_ready never asserted, s_valid=0.
- resetn low during an OWN0 stall -> next cycle grant=00, s_valid=0, all ready=0; after release, m0 wins the first tie.
